// File: rtl/lfsr_rng_ranged.sv
// Fibonacci LFSR random source with a req/valid/ack ranged-draw engine (rejection, then fold fallback).
// Optional build macro RNG_REJECT_CNT_EN adds a saturating reject_cnt[15:0] output.
module lfsr_rng_ranged #(
    parameter int                LFSR_W    = 21,
    parameter int                TAP_A     = 20,
    parameter int                TAP_B     = 17,
    parameter int                OUT_W     = 8,
    parameter logic [LFSR_W-1:0] SEED      = {LFSR_W{1'b1}},
    parameter int                MAX_TRIES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    output logic [OUT_W-1:0]  raw,
    input  logic              req,
    input  logic [OUT_W-1:0]  range,
    output logic              busy,
    output logic [OUT_W-1:0]  rnd,
    output logic              rnd_valid,
    input  logic              ack
`ifdef RNG_REJECT_CNT_EN
    ,
    output logic [15:0]       reject_cnt
`endif
);

    localparam int                TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0]  TRY_LAST = TRY_W'(MAX_TRIES - 1);

    typedef enum logic [1:0] {IDLE, DRAW, FOLD, HOLD} state_t;

    state_t             state;
    logic [LFSR_W-1:0]  lfsr;
    logic [TRY_W-1:0]   tries;
    logic [OUT_W-1:0]   range_q;
    logic [OUT_W-1:0]   work;
    logic [OUT_W-1:0]   cand;
    logic               accept;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[TAP_A] ^ s[TAP_B]};
    endfunction

    assign raw    = lfsr[OUT_W-1:0];
    assign cand   = lfsr[OUT_W-1:0];
    assign accept = (range_q == '0) || (cand < range_q);

    // Zero seeds are replaced by SEED so the register can never start locked up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr <= SEED;
        else if (seed_load)
            lfsr <= (seed_in == '0) ? SEED : seed_in;
        else if (lfsr == '0)
            lfsr <= SEED;
        else if (en || state == DRAW)
            lfsr <= lfsr_next(lfsr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rnd       <= '0;
            rnd_valid <= 1'b0;
            busy      <= 1'b0;
            tries     <= '0;
            range_q   <= '0;
            work      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        range_q <= range;
                        tries   <= '0;
                        busy    <= 1'b1;
                        state   <= DRAW;
                    end
                end
                DRAW: begin
                    if (accept) begin
                        rnd       <= cand;
                        busy      <= 1'b0;
                        rnd_valid <= 1'b1;
                        state     <= HOLD;
                    end else if (tries == TRY_LAST) begin
                        work  <= cand;
                        state <= FOLD;
                    end else begin
                        tries <= tries + TRY_W'(1);
                    end
                end
                // range_q is nonzero here: a zero range always accepts in DRAW.
                FOLD: begin
                    if (work >= range_q) begin
                        work <= work - range_q;
                    end else begin
                        rnd       <= work;
                        busy      <= 1'b0;
                        rnd_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (ack) begin
                        rnd_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RNG_REJECT_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            reject_cnt <= '0;
        else if (seed_load)
            reject_cnt <= '0;
        else if (state == DRAW && !accept)
            reject_cnt <= sat_inc16(reject_cnt);
    end
`endif

endmodule
